uart_rx: RTL and testbench

Serial-to-parallel UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity by default. It samples each bit at its midpoint and returns one byte per frame with a single-cycle valid strobe. It sits directly downstream of the UART transmitter on the serial line and is the receive-side counterpart for loopback and host-link paths. It uses the same `CLKS_PER_BIT` convention as the transmitter: clock frequency / baud rate.

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-data-bit, LSB-first UART receiver with mid-bit sampling and one-cycle strobes.
// Define UART_RX_PARITY_EN to receive and check an even parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       RX_Serial,
  output logic [7:0] RX_Byte,
  output logic       RX_Valid,
  output logic       RX_Active,
  output logic       RX_Frame_Err,
  output logic       RX_Parity_Err
);

  localparam logic [9:0] CNT_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] CNT_HALF = 10'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q, rx_s;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       ferr_q, ferr_d;
  logic       cnt_done_s, cnt_half_s, idx_last_s, par_good_s;

`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       perr_q, perr_d;

  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

  assign par_good_s = even_parity_ok(shift_q, par_q);
`else
  assign par_good_s = 1'b1;
`endif

  assign rx_s       = sync2_q;
  assign cnt_done_s = (cnt_q == CNT_LAST);
  assign cnt_half_s = (cnt_q == CNT_HALF);
  assign idx_last_s = (idx_q == 3'd7);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
        else       state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_half_s) state_d = rx_s ? S_IDLE : S_DATA;
        else            state_d = S_START;
      end
      S_DATA: begin
        if (cnt_done_s && idx_last_s) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_done_s) state_d = S_STOP;
        else            state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (cnt_done_s) state_d = S_IDLE;
        else            state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; strobes default low every cycle
  always_comb begin
    cnt_d    = cnt_q + 10'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    active_d = (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 10'd0;
        idx_d = 3'd0;
      end
      S_START: begin
        if (cnt_half_s) cnt_d = 10'd0;
        else            cnt_d = cnt_q + 10'd1;
      end
      S_DATA: begin
        if (cnt_done_s) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = 10'd0;
          idx_d          = idx_last_s ? 3'd0 : idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_done_s) begin
          par_d = rx_s;
          cnt_d = 10'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_done_s) begin
          cnt_d  = 10'd0;
          ferr_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d = ~par_good_s;
`endif
          if (rx_s && par_good_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            byte_d  = byte_q;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        cnt_d = 10'd0;
        idx_d = 3'd0;
      end
    endcase
  end

  // Synchronizer, datapath and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= 10'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      sync1_q  <= RX_Serial;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign RX_Byte      = byte_q;
  assign RX_Valid     = valid_q;
  assign RX_Active    = active_q;
  assign RX_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign RX_Parity_Err = perr_q;
`else
  assign RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 16: frame table plus glitch and reset sequences.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif
  // Strobe edge relative to t0: 3 + H + (FB-1)*N  ->  154, or 170 with parity
  localparam int STOP_J = 3 + 7 + (FB - 1) * N;

  logic       Clock, Reset, RX_Serial;
  logic [7:0] RX_Byte;
  logic       RX_Valid, RX_Active, RX_Frame_Err, RX_Parity_Err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop_b;
    logic       par_bad;
    int         idle;
    int         exp_valid;
    logic [7:0] exp_byte;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  typedef struct {
    int         nvalid, valid_at, valid_abs;
    int         nferr, ferr_at, nperr, perr_at;
    int         act_rise, act_fall;
    logic [11:0] snap;
    logic [7:0]  byte_end;
  } res_t;

  vec_t vecs[$];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .Clock(Clock), .Reset(Reset), .RX_Serial(RX_Serial),
    .RX_Byte(RX_Byte), .RX_Valid(RX_Valid), .RX_Active(RX_Active),
    .RX_Frame_Err(RX_Frame_Err), .RX_Parity_Err(RX_Parity_Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input logic stop_b,
                                    input logic par_b, input int s);
    if (s == 0)                 return 1'b0;
    else if (s <= 8)            return b[s-1];
    else if (PAR && s == 9)     return par_b;
    else if (s == FB - 1)       return stop_b;
    else                        return 1'b1;
  endfunction

  // Drives one frame starting now (t0 = next edge) and records every DUT event relative to t0
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                            input int idle, input int rst_at, output res_t r);
    bit aborted;
    int j;
    aborted = 1'b0;
    r = '{nvalid: 0, valid_at: -1, valid_abs: -1, nferr: 0, ferr_at: -1, nperr: 0,
          perr_at: -1, act_rise: -1, act_fall: -1, snap: 12'hFFF, byte_end: 8'h00};
    RX_Serial = 1'b0;
    for (int i = 1; i <= FB * N + idle; i++) begin
      tick();
      j = i - 1;
      if (RX_Valid)      begin r.nvalid++; r.valid_at = j; r.valid_abs = cyc; end
      if (RX_Frame_Err)  begin r.nferr++;  r.ferr_at  = j; end
      if (RX_Parity_Err) begin r.nperr++;  r.perr_at  = j; end
      if (RX_Active && r.act_rise < 0) r.act_rise = j;
      else if (!RX_Active && r.act_rise >= 0 && r.act_fall < 0) r.act_fall = j;
      if (rst_at >= 0 && j == rst_at + 1) begin
        r.snap = {RX_Byte, RX_Valid, RX_Active, RX_Frame_Err, RX_Parity_Err};
        Reset  = 1'b0;
      end
      if (j == rst_at) begin
        Reset     = 1'b1;
        aborted   = 1'b1;
        RX_Serial = 1'b1;
      end else if (!aborted && (i % N) == 0) begin
        RX_Serial = line_bit(b, stop_b, par_b, i / N);
      end
      r.byte_end = RX_Byte;
    end
  endtask

  initial begin
    res_t r, prev;
    int   prev_idle;
    int   a9, a10, gstrobe;

    Reset     = 1'b1;
    RX_Serial = 1'b1;
    repeat (3) tick();
    chk("reset byte",   int'(RX_Byte), 0);
    chk("reset valid",  int'(RX_Valid), 0);
    chk("reset active", int'(RX_Active), 0);
    chk("reset ferr",   int'(RX_Frame_Err), 0);
    chk("reset perr",   int'(RX_Parity_Err), 0);
    Reset = 1'b0;
    repeat (4) tick();
    chk("idle active",  int'(RX_Active), 0);
    chk("idle valid",   int'(RX_Valid), 0);

    // b, stop, par_bad, idle | exp_valid, exp_byte, exp_ferr, exp_perr
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0,     1, 8'hA5, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0,     1, 8'h00, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,     1, 8'hFF, 0, 0});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 0,     1, 8'h3C, 0, 0});
    vecs.push_back('{8'hC3, 1'b0, 1'b0, 2 * N, 0, 8'h3C, 1, 0});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, N,     1, 8'h5A, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0,     1, 8'h07, 0, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, N,     0, 8'h07, 0, 1});
    vecs.push_back('{8'hE1, 1'b0, 1'b1, 2 * N, 0, 8'h07, 1, 1});
    vecs.push_back('{8'h96, 1'b1, 1'b0, N,     1, 8'h96, 0, 0});
`endif

    prev_idle = -1;
    prev = '{nvalid: 0, valid_at: -1, valid_abs: -1, nferr: 0, ferr_at: -1, nperr: 0,
             perr_at: -1, act_rise: -1, act_fall: -1, snap: 12'h000, byte_end: 8'h00};
    foreach (vecs[i]) begin
      send_frame(vecs[i].b, vecs[i].stop_b, (^vecs[i].b) ^ vecs[i].par_bad,
                 vecs[i].idle, -1, r);
      chk($sformatf("v%0d valid count", i), r.nvalid, vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0) chk($sformatf("v%0d valid time", i), r.valid_at, STOP_J);
      chk($sformatf("v%0d ferr count", i), r.nferr, vecs[i].exp_ferr);
      if (vecs[i].exp_ferr != 0) chk($sformatf("v%0d ferr time", i), r.ferr_at, STOP_J);
      chk($sformatf("v%0d perr count", i), r.nperr, vecs[i].exp_perr);
      if (vecs[i].exp_perr != 0) chk($sformatf("v%0d perr time", i), r.perr_at, STOP_J);
      chk($sformatf("v%0d active rise", i), r.act_rise, 2);
      chk($sformatf("v%0d active fall", i), r.act_fall, STOP_J);
      chk($sformatf("v%0d byte", i), int'(r.byte_end), int'(vecs[i].exp_byte));
      if (prev_idle == 0 && prev.nvalid == 1 && r.nvalid == 1)
        chk($sformatf("v%0d valid spacing", i), r.valid_abs - prev.valid_abs, FB * N);
      prev      = r;
      prev_idle = vecs[i].idle;
    end

    // 5-cycle start glitch: FSM must bail out at mid-start-bit with no strobe
    RX_Serial = 1'b0;
    a9 = -1; a10 = -1; gstrobe = 0;
    for (int i = 1; i <= 3 * N; i++) begin
      tick();
      if (i - 1 == 9)  a9  = int'(RX_Active);
      if (i - 1 == 10) a10 = int'(RX_Active);
      gstrobe += int'(RX_Valid) + int'(RX_Frame_Err) + int'(RX_Parity_Err);
      if (i == 5) RX_Serial = 1'b1;
    end
    chk("glitch active t0+9", a9, 1);
    chk("glitch active t0+10", a10, 0);
    chk("glitch strobes", gstrobe, 0);
    send_frame(8'h5A, 1'b1, ^(8'h5A), N, -1, r);
    chk("post-glitch valid count", r.nvalid, 1);
    chk("post-glitch valid time", r.valid_at, STOP_J);
    chk("post-glitch byte", int'(r.byte_end), 32'h5A);

    // Reset during data bit 3 (bit 3 sampled at t0+74)
    send_frame(8'h96, 1'b1, ^(8'h96), N, 70, r);
    chk("midreset outputs", int'(r.snap), 0);
    chk("midreset valid count", r.nvalid, 0);
    chk("midreset ferr count", r.nferr, 0);
    chk("midreset perr count", r.nperr, 0);
    chk("midreset byte after", int'(r.byte_end), 0);
    send_frame(8'h81, 1'b1, ^(8'h81), N, -1, r);
    chk("post-reset valid count", r.nvalid, 1);
    chk("post-reset valid time", r.valid_at, STOP_J);
    chk("post-reset byte", int'(r.byte_end), 32'h81);
    chk("post-reset ferr count", r.nferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
